pixel_writer: RTL and testbench
===============================

# pixel_writer

Consumer end of the line-drawing pixel stream. Accepts (X, Y) pixel coordinates from the line rasteriser over a valid/ready handshake, buffers them in a small FIFO, and renders each pixel into a 256×256, 1-bit-per-pixel framebuffer held in byte-wide synchronous RAM. Each pixel is applied by read-modify-write. A one-byte write-back cache skips the read when consecutive pixels fall in the same byte.

## Interface

**Parameters**
- `DEPTH`, default 4: pixel FIFO depth. Power of two, ≥2.

**Ports** (name, direction, width, meaning)
- `ACLK`, in, 1: clock. All logic is on the rising edge.
- `ARST`, in, 1: reset. Asynchronous, active-high.
- `PIX_VALID`, in, 1: a pixel is presented on `X_In`/`Y_In`/`MODE`.
- `PIX_READY`, out, 1: FIFO can accept a pixel. Equals `!full`.
- `X_In`, in, 8: pixel column.
- `Y_In`, in, 8: pixel row.
- `MODE`, in, 2: pixel operation. 00 = set, 01 = clear, 10 = xor, 11 = discard.
- `MEM_ADDR`, out, 13: byte address, `{Y, X[7:3]}`.
- `MEM_RE`, out, 1: read strobe. The RAM samples the address at the edge that ends the strobe cycle.
- `MEM_RDATA`, in, 8: read data. Valid during the cycle after `MEM_RE`.
- `MEM_WE`, out, 1: write strobe.
- `MEM_WDATA`, out, 8: write data. Pixel bit index is `X[2:0]`.
- `BUSY`, out, 1: FIFO non-empty or FSM not in IDLE.

## Operation

- **Push:** a pixel is pushed on an edge where `PIX_VALID && PIX_READY`.
  - `PIX_READY` is low whenever the FIFO is full, even if a pop occurs on the same edge. There is no bypass.
- **Pop:** the FIFO is registered with no fall-through. A pop loads the head into working registers `px`, `py`, `pmode`.
- **Cache:** `cvalid`, `caddr[12:0]`, `cdata[7:0]`. It is the last byte written. This block owns the framebuffer exclusively, so the cache is never stale.
- **FSM states:** IDLE, RD, WAIT, WR.
  - **IDLE:** if FIFO is non-empty, pop, then branch:
    - `pmode`=11: stay IDLE. No memory access.
    - Hit (`cvalid && caddr=={py,px[7:3]}`): go WR with base byte = `cdata`.
    - Otherwise: go RD.
  - **RD:** `MEM_RE=1`, `MEM_ADDR={py,px[7:3]}`. Go WAIT.
  - **WAIT:** latch `MEM_RDATA` as the base byte. Go WR.
  - **WR:** `MEM_WE=1`, `MEM_ADDR` held, `MEM_WDATA` = base byte with bit `px[2:0]` modified per `pmode` (set, clear, or invert).
    - Update cache: `cvalid=1`, `caddr`, `cdata=MEM_WDATA`.
    - If FIFO is non-empty, pop on the same edge and branch as in IDLE; a discard goes to IDLE. Otherwise go IDLE.
- **Strobes:** `MEM_RE` and `MEM_WE` are never high together. Writes occur in FIFO order.
- **Arithmetic:** no carries. Address is pure concatenation. Bit selection is a 3-bit index.

## Timing

- **Reset values:**
  - `PIX_READY`=1 (FIFO empty).
  - `MEM_ADDR`=0, `MEM_RE`=0, `MEM_WE`=0, `MEM_WDATA`=0, `BUSY`=0.
  - FSM in IDLE, `cvalid`=0.
- **Reset mid-operation:**
  - Outputs go to reset values immediately (asynchronously), including a `MEM_WE` pulse in flight.
  - FIFO contents are dropped and the cache is invalidated.
- **Latency:** pixel pushed at edge E0 → popped at E1 → RD cycle E1–E2 → WAIT E2–E3 → `MEM_WE` high E3–E4. The write commits at E4.
- **Throughput:**
  - Cache miss: 3 cycles/pixel.
  - Cache hit: 1 cycle/pixel (WR→WR back-to-back).
  - Discard: 1 cycle.
- **Full FIFO:** `PIX_READY` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the next pop.
- **Simultaneous push and pop on a non-full FIFO:** both take effect; occupancy is unchanged.
- **`BUSY`:** falls in the cycle after the last WR with the FIFO empty.

## Test plan

- **Reset:** assert `ARST` mid-run → all outputs read reset values within the same cycle; `PIX_READY`=1, `BUSY`=0.
- **Single pixel:** set X=13, Y=2, RAM byte 65 = 0x00 → `MEM_RE` with `MEM_ADDR`=65. Then `MEM_WE` with `MEM_ADDR`=65, `MEM_WDATA`=0x20, three cycles after the accept edge.
- **Cache hits:** set X=8..15 on Y=0, one pixel per cycle, RAM byte 1 = 0x00 → exactly one `MEM_RE` at addr 1, then eight consecutive `MEM_WE` at addr 1. `MEM_WDATA` runs 0x01, 0x03, … 0xFF; 10 cycles from first pop to last write.
- **Modes:** RAM 0xFF, xor X=0 → 0xFE. Clear X=7 on byte 0xFF → 0x7F. Discard (MODE=11) → no `MEM_RE`/`MEM_WE`, consumes 1 cycle.
- **Backpressure:** present 8 distinct-byte pixels continuously with `DEPTH`=4 → `PIX_READY` deasserts once 4 are buffered. All 8 written in order at 3-cycle spacing; none lost or duplicated.
- **Reset during WR:** assert `ARST` while `MEM_WE`=1 → `MEM_WE` drops immediately. After release, a pixel at the same byte issues a full RD (cache invalidated).

Source files
------------

// File: rtl/pixel_writer.sv
// Pixel stream consumer: buffers (X, Y, MODE) in a small FIFO and applies each pixel to a
// 256x256 1bpp framebuffer by read-modify-write, skipping the read when the last written byte is hit.
module pixel_writer #(
    parameter int DEPTH = 4
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        PIX_VALID,
    output logic        PIX_READY,
    input  logic [7:0]  X_In,
    input  logic [7:0]  Y_In,
    input  logic [1:0]  MODE,
    output logic [12:0] MEM_ADDR,
    output logic        MEM_RE,
    input  logic [7:0]  MEM_RDATA,
    output logic        MEM_WE,
    output logic [7:0]  MEM_WDATA,
    output logic        BUSY
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WAIT = 2'd2,
        S_WR   = 2'd3
    } state_t;

    function automatic logic [7:0] apply_pix(input logic [7:0] base_byte,
                                             input logic [2:0] bit_idx,
                                             input logic [1:0] op);
        logic [7:0] mask;
        logic [7:0] result;
        mask = 8'd1 << bit_idx;
        case (op)
            2'b00:   result = base_byte | mask;
            2'b01:   result = base_byte & ~mask;
            2'b10:   result = base_byte ^ mask;
            default: result = base_byte;
        endcase
        return result;
    endfunction

    // FIFO entries are packed {mode, y, x}
    logic [17:0]   fifo_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_s;

    state_t        state_r, state_s;
    logic [7:0]    px_r, py_r;
    logic [1:0]    pmode_r;
    logic          cvalid_r;
    logic [12:0]   caddr_r;
    logic [7:0]    cdata_r;

    logic          pix_ready_r, mem_re_r, mem_we_r, busy_r;
    logic [12:0]   mem_addr_r;
    logic [7:0]    mem_wdata_r;

    logic [17:0]   head_s;
    logic [12:0]   head_addr_s, addr_s;
    logic [7:0]    wdata_s;
    logic          hit_s, push_s, pop_s, re_s, we_s, cache_ld_s, ready_s, busy_s;

    // Next-state, pop decision and next values of the registered memory-side outputs
    always_comb begin
        head_s      = fifo_mem_r[rd_ptr_r];
        head_addr_s = {head_s[15:8], head_s[7:3]};
        hit_s       = cvalid_r && (caddr_r == head_addr_s);
        push_s      = PIX_VALID && pix_ready_r;
        pop_s       = 1'b0;
        state_s     = state_r;
        re_s        = 1'b0;
        we_s        = 1'b0;
        addr_s      = mem_addr_r;
        wdata_s     = mem_wdata_r;
        cache_ld_s  = 1'b0;
        case (state_r)
            S_IDLE, S_WR: begin
                if (count_r != {CW{1'b0}}) begin
                    pop_s = 1'b1;
                    if (head_s[17:16] == 2'b11) begin
                        state_s = S_IDLE;
                    end else if (hit_s) begin
                        state_s    = S_WR;
                        we_s       = 1'b1;
                        addr_s     = head_addr_s;
                        wdata_s    = apply_pix(cdata_r, head_s[2:0], head_s[17:16]);
                        cache_ld_s = 1'b1;
                    end else begin
                        state_s = S_RD;
                        re_s    = 1'b1;
                        addr_s  = head_addr_s;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                state_s    = S_WR;
                we_s       = 1'b1;
                addr_s     = {py_r, px_r[7:3]};
                wdata_s    = apply_pix(MEM_RDATA, px_r[2:0], pmode_r);
                cache_ld_s = 1'b1;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        count_s = count_r + CW'(push_s) - CW'(pop_s);
        ready_s = (count_s != CW'(DEPTH));
        busy_s  = (count_s != {CW{1'b0}}) || (state_s != S_IDLE);
    end

    // FIFO storage needs no reset: occupancy and pointers define what is live
    always_ff @(posedge ACLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {MODE, Y_In, X_In};
        end
    end

    // FIFO control, FSM state and the working pixel registers
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            state_r  <= S_IDLE;
            px_r     <= 8'd0;
            py_r     <= 8'd0;
            pmode_r  <= 2'd0;
        end else begin
            count_r <= count_s;
            state_r <= state_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                px_r     <= head_s[7:0];
                py_r     <= head_s[15:8];
                pmode_r  <= head_s[17:16];
            end
        end
    end

    // The cache is loaded as the write is launched, so a back-to-back pixel sees the byte in flight
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            cvalid_r    <= 1'b0;
            caddr_r     <= 13'd0;
            cdata_r     <= 8'd0;
            pix_ready_r <= 1'b1;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 13'd0;
            mem_wdata_r <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            if (cache_ld_s) begin
                cvalid_r <= 1'b1;
                caddr_r  <= addr_s;
                cdata_r  <= wdata_s;
            end
            pix_ready_r <= ready_s;
            mem_re_r    <= re_s;
            mem_we_r    <= we_s;
            mem_addr_r  <= addr_s;
            mem_wdata_r <= wdata_s;
            busy_r      <= busy_s;
        end
    end

    assign PIX_READY = pix_ready_r;
    assign MEM_ADDR  = mem_addr_r;
    assign MEM_RE    = mem_re_r;
    assign MEM_WE    = mem_we_r;
    assign MEM_WDATA = mem_wdata_r;
    assign BUSY      = busy_r;

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: a pixel-level framebuffer model predicts every write,
// a byte RAM fixture answers the DUT, and a monitor compares reads/writes as they appear.
module tb_pixel_writer;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b1;
    logic        PIX_VALID = 1'b0;
    logic        PIX_READY;
    logic [7:0]  X_In = 8'd0;
    logic [7:0]  Y_In = 8'd0;
    logic [1:0]  MODE = 2'd0;
    logic [12:0] MEM_ADDR;
    logic        MEM_RE;
    logic [7:0]  MEM_RDATA;
    logic        MEM_WE;
    logic [7:0]  MEM_WDATA;
    logic        BUSY;

    always #5 ACLK = ~ACLK;

    pixel_writer #(.DEPTH(4)) dut (
        .ACLK(ACLK), .ARST(ARST), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .X_In(X_In), .Y_In(Y_In), .MODE(MODE), .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE),
        .MEM_RDATA(MEM_RDATA), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .BUSY(BUSY)
    );

    // Byte-wide synchronous RAM fixture
    logic [7:0]  ram [0:8191];
    logic        init_en = 1'b0;
    logic        poke_en = 1'b0;
    logic [12:0] poke_addr = 13'd0;
    logic [7:0]  poke_data = 8'd0;

    always @(posedge ACLK) begin
        if (init_en) for (int i = 0; i < 8192; i++) ram[i] <= 8'($urandom);
        if (poke_en) ram[poke_addr] <= poke_data;
        if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
        if (MEM_RE) MEM_RDATA <= ram[MEM_ADDR];
    end

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
        logic        need_read;
    } exp_t;

    exp_t        sb_q[$];
    bit          fb [256][256];
    int          checks, failures;
    int          cyc, n_acc, n_re, n_we, last_we_cyc;
    int          acc_hist[int];
    int          we_hist[int];
    bit          c_valid, need_sync, got_read, pr_low_seen;
    logic [12:0] c_addr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [12:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge ACLK);
        poke_en   = 1'b0;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
        bit rdy;
        bit done;
        done      = 1'b0;
        PIX_VALID = 1'b1;
        X_In = x; Y_In = y; MODE = m;
        for (int t = 0; t < 200 && !done; t++) begin
            rdy = PIX_READY;
            @(negedge ACLK);
            done = rdy;
        end
        if (!done) begin
            check("send_timeout", 0, 1);
            PIX_VALID = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (BUSY && k < 300) begin
            @(negedge ACLK);
            k++;
        end
        if (k >= 300) check("idle_timeout", k, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, PIX_READY, 1);
        check({tag, "_addr"},  MEM_ADDR, 0);
        check({tag, "_re"},    MEM_RE, 0);
        check({tag, "_we"},    MEM_WE, 0);
        check({tag, "_wdata"}, MEM_WDATA, 0);
        check({tag, "_busy"},  BUSY, 0);
    endtask

    initial begin
        int r0, w0, a0, k, mism;
        logic [7:0] lx, ly, ex;
        checks = 0; failures = 0; cyc = 0; n_acc = 0; n_re = 0; n_we = 0;
        last_we_cyc = 0; c_valid = 1'b0; need_sync = 1'b1; got_read = 1'b0;
        pr_low_seen = 1'b0; c_addr = 13'd0;

        fork
            // Input-side model: every accepted pixel updates the reference framebuffer
            forever begin
                logic [12:0] a;
                logic [7:0]  e;
                @(posedge ACLK);
                if (ARST) begin
                    c_valid   = 1'b0;
                    need_sync = 1'b1;
                end else if (need_sync) begin
                    for (int yy = 0; yy < 256; yy++)
                        for (int xx = 0; xx < 256; xx++) begin
                            logic [7:0] ty, tx;
                            ty = 8'(yy); tx = 8'(xx);
                            fb[yy][xx] = ram[{ty, tx[7:3]}][tx[2:0]];
                        end
                    need_sync = 1'b0;
                end
                if (poke_en)
                    for (int b = 0; b < 8; b++) fb[poke_addr[12:5]][{poke_addr[4:0], 3'(b)}] = poke_data[b];
                if (!ARST && PIX_VALID && PIX_READY) begin
                    acc_hist[n_acc] = cyc;
                    n_acc++;
                    if (MODE != 2'b11) begin
                        a = {Y_In, X_In[7:3]};
                        case (MODE)
                            2'b00:   fb[Y_In][X_In] = 1'b1;
                            2'b01:   fb[Y_In][X_In] = 1'b0;
                            default: fb[Y_In][X_In] = ~fb[Y_In][X_In];
                        endcase
                        for (int b = 0; b < 8; b++) e[b] = fb[Y_In][{X_In[7:3], 3'(b)}];
                        sb_q.push_back('{a, e, !(c_valid && c_addr == a)});
                        c_valid = 1'b1;
                        c_addr  = a;
                    end
                end
                cyc++;
            end
            // Output-side monitor: match reads and writes against the expected queue
            forever begin
                exp_t it;
                @(negedge ACLK);
                if (ARST) begin
                    sb_q.delete();
                    got_read = 1'b0;
                end else begin
                    if (!PIX_READY) pr_low_seen = 1'b1;
                    if (MEM_RE || MEM_WE) check("re_we_exclusive", MEM_RE && MEM_WE, 0);
                    if (MEM_RE) begin
                        n_re++;
                        check("rd_expected", sb_q.size() > 0, 1);
                        if (sb_q.size() > 0) begin
                            check("rd_needed", sb_q[0].need_read && !got_read, 1);
                            check("rd_addr", MEM_ADDR, sb_q[0].addr);
                        end
                        got_read = 1'b1;
                    end
                    if (MEM_WE) begin
                        we_hist[n_we] = cyc;
                        n_we++;
                        last_we_cyc = cyc;
                        check("wr_expected", sb_q.size() > 0, 1);
                        if (sb_q.size() > 0) begin
                            it = sb_q.pop_front();
                            check("wr_addr", MEM_ADDR, it.addr);
                            check("wr_data", MEM_WDATA, it.data);
                            check("wr_read_before", got_read, it.need_read);
                        end
                        got_read = 1'b0;
                    end
                end
            end
        join_none

        repeat (2) @(negedge ACLK);
        init_en = 1'b1;
        @(negedge ACLK);
        init_en = 1'b0;
        @(negedge ACLK);
        check_reset_outputs("reset");
        ARST = 1'b0;
        repeat (2) @(negedge ACLK);

        // single pixel X=13 Y=2 into byte 65
        poke(13'd65, 8'h00);
        r0 = n_re;
        send(8'd13, 8'd2, 2'b00);
        PIX_VALID = 1'b0;
        wait_idle();
        check("single_reads", n_re - r0, 1);
        check("single_latency", last_we_cyc - acc_hist[n_acc-1], 4);
        check("single_ram", ram[65], 8'h20);

        // eight hits in byte 1
        poke(13'd1, 8'h00);
        r0 = n_re; w0 = n_we; a0 = n_acc;
        for (int x = 8; x < 16; x++) send(8'(x), 8'd0, 2'b00);
        PIX_VALID = 1'b0;
        wait_idle();
        check("hit_reads", n_re - r0, 1);
        check("hit_writes", n_we - w0, 8);
        check("hit_span", last_we_cyc - acc_hist[a0], 11);
        check("hit_ram", ram[1], 8'hFF);

        // xor and clear on 0xFF bytes
        poke(13'd320, 8'hFF);
        poke(13'd321, 8'hFF);
        send(8'd0, 8'd10, 2'b10);
        send(8'd15, 8'd10, 2'b01);
        PIX_VALID = 1'b0;
        wait_idle();
        check("xor_ram", ram[320], 8'hFE);
        check("clear_ram", ram[321], 8'h7F);

        // discard: no memory traffic, busy for one cycle
        r0 = n_re; w0 = n_we;
        send(8'd40, 8'd40, 2'b11);
        PIX_VALID = 1'b0;
        check("discard_busy_on", BUSY, 1);
        @(negedge ACLK);
        check("discard_busy_off", BUSY, 0);
        repeat (3) @(negedge ACLK);
        check("discard_reads", n_re - r0, 0);
        check("discard_writes", n_we - w0, 0);

        // backpressure with 8 distinct bytes
        pr_low_seen = 1'b0;
        w0 = n_we;
        for (int i = 0; i < 8; i++) send(8'(i * 8), 8'd5, 2'b00);
        PIX_VALID = 1'b0;
        wait_idle();
        check("bp_ready_low", pr_low_seen, 1);
        check("bp_writes", n_we - w0, 8);
        for (int i = 1; i < 8; i++) check("bp_spacing", we_hist[w0+i] - we_hist[w0+i-1], 3);

        // reset while a write is in flight
        send(8'd20, 8'd7, 2'b00);
        PIX_VALID = 1'b0;
        k = 0;
        while (!MEM_WE && k < 20) begin
            @(negedge ACLK);
            k++;
        end
        check("wr_seen_before_reset", MEM_WE, 1);
        ARST = 1'b1;
        #1;
        check_reset_outputs("wr_reset");
        repeat (2) @(negedge ACLK);
        ARST = 1'b0;
        repeat (2) @(negedge ACLK);
        r0 = n_re;
        send(8'd21, 8'd7, 2'b00);
        PIX_VALID = 1'b0;
        wait_idle();
        check("post_reset_read", n_re - r0, 1);

        // randomized stream with gaps, same-byte bias and one mid-run reset
        lx = 8'd0;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                PIX_VALID = 1'b0;
                ARST = 1'b1;
                #1;
                check("rand_reset_busy", BUSY, 0);
                check("rand_reset_we", MEM_WE, 0);
                repeat (2) @(negedge ACLK);
                ARST = 1'b0;
                repeat (2) @(negedge ACLK);
            end
            if ($urandom_range(0, 1) == 0) lx = {lx[7:3], 3'($urandom)};
            else lx = 8'($urandom);
            ly = 8'($urandom_range(0, 3));
            send(lx, ly, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                PIX_VALID = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge ACLK);
            end
        end
        PIX_VALID = 1'b0;
        wait_idle();
        repeat (2) @(negedge ACLK);
        check("sb_drained", sb_q.size(), 0);
        mism = 0;
        for (int yy = 0; yy < 256; yy++)
            for (int xb = 0; xb < 32; xb++) begin
                for (int b = 0; b < 8; b++) ex[b] = fb[yy][xb*8+b];
                if (ram[yy*32+xb] != ex) mism++;
            end
        check("framebuffer_match", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
